// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host transmitter.
// The master side issues command bytes. The slave side is the transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, rx_inhibit, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, rx_inhibit, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// It inhibits the bus, issues request-to-send and then shifts one command byte
// out on the device-generated clock: LSB first, odd parity, then a stop bit.
// It then samples the device acknowledge bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, waiting for a command byte
// INHIBIT  | holding the clock line low before request-to-send
// RTS      | one cycle with clock and data low (start bit on the line)
// WAIT_CLK | clock released, waiting for the device's first falling edge
// SHIFT    | driving data bits, parity and stop on successive falling edges
// RELEASE  | ack sampled, waiting for both lines to return high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int PACKET_TIMEOUT = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  ps2_host_tx_if.slave host,
  input  logic         key_clk_i,
  input  logic         key_data_i,
  output logic         key_clk_oe,
  output logic         key_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int STA_W = $clog2(START_TIMEOUT + 1);
  localparam int PKT_W = $clog2(PACKET_TIMEOUT + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_CLK, SHIFT, RELEASE
  } state_t;

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             clk_acc, fall;
  logic [FLT_W-1:0] flt_cnt;

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [STA_W-1:0] sta_q, sta_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [3:0]       edge_q, edge_d;
  logic             ack_q, ack_d;
  logic             dbit_q, dbit_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  // Two-flop synchronisers for the raw lines; idle level of both lines is high.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= key_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= key_data_i;
      dat_s2 <= dat_s1;
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_acc <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == clk_acc) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_acc <= clk_s2;
        flt_cnt <= '0;
        fall    <= clk_acc;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  // State and datapath registers; reset drops everything back to an idle, released bus.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      inh_q   <= '0;
      sta_q   <= '0;
      pkt_q   <= '0;
      edge_q  <= '0;
      ack_q   <= 1'b0;
      dbit_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      inh_q   <= inh_d;
      sta_q   <= sta_d;
      pkt_q   <= pkt_d;
      edge_q  <= edge_d;
      ack_q   <= ack_d;
      dbit_q  <= dbit_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next-state, counter and bit-sequencing logic.
  // Timeout counters count down and stop at their terminal count of zero.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    inh_d   = inh_q;
    sta_d   = sta_q;
    pkt_d   = pkt_q;
    edge_d  = edge_q;
    ack_d   = ack_q;
    dbit_d  = dbit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (host.tx_valid) begin
          shreg_d = host.tx_data;
          par_d   = ~^host.tx_data;
          inh_d   = INH_W'(INHIBIT_CYCLES - 1);
          edge_d  = '0;
          code_d  = 2'b00;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == '0) state_d = RTS;
        else             inh_d   = inh_q - INH_W'(1);
      end
      RTS: begin
        sta_d   = STA_W'(START_TIMEOUT - 1);
        state_d = WAIT_CLK;
      end
      WAIT_CLK: begin
        if (fall) begin
          edge_d  = 4'd1;
          dbit_d  = ~shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          pkt_d   = PKT_W'(PACKET_TIMEOUT - 1);
          state_d = SHIFT;
        end else if (sta_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = IDLE;
        end else begin
          sta_d = sta_q - STA_W'(1);
        end
      end
      SHIFT: begin
        if (pkt_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          dbit_d  = 1'b0;
          state_d = IDLE;
        end else begin
          pkt_d = pkt_q - PKT_W'(1);
          if (fall) begin
            // edge_q holds the count before this edge, so edge n is edge_q == n-1.
            edge_d = edge_q + 4'd1;
            if (edge_q <= 4'd7) begin
              dbit_d  = ~shreg_q[0];
              shreg_d = {1'b0, shreg_q[7:1]};
            end else if (edge_q == 4'd8) begin
              dbit_d = ~par_q;
            end else if (edge_q == 4'd9) begin
              dbit_d = 1'b0;
            end else begin
              ack_d   = dat_s2;
              state_d = RELEASE;
            end
          end
        end
      end
      RELEASE: begin
        if (pkt_q == '0) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else begin
          pkt_d = pkt_q - PKT_W'(1);
          if (clk_acc && dat_s2) begin
            done_d  = ~ack_q;
            err_d   = ack_q;
            if (ack_q) code_d = 2'b11;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drivers depend on state only, so any return to IDLE releases the bus.
  always_comb begin
    key_clk_oe  = 1'b0;
    key_data_oe = 1'b0;
    case (state_q)
      INHIBIT:  key_clk_oe  = 1'b1;
      RTS: begin
        key_clk_oe  = 1'b1;
        key_data_oe = 1'b1;
      end
      WAIT_CLK: key_data_oe = 1'b1;
      SHIFT:    key_data_oe = dbit_q;
      default: begin
        key_clk_oe  = 1'b0;
        key_data_oe = 1'b0;
      end
    endcase
  end

  assign host.tx_ready   = (state_q == IDLE);
  assign host.busy       = (state_q != IDLE);
  assign host.rx_inhibit = (state_q != IDLE);
  assign host.done       = done_q;
  assign host.err        = err_q;
  assign host.err_code   = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for the PS/2 host transmitter: a behavioural keyboard model clocks
// frames out of the DUT and records the bits it sees on rising edges.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int STO = 200;
  localparam int PTO = 400;
  localparam int FLT = 4;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic key_clk_i, key_data_i, key_clk_oe, key_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ps2_host_tx_if intf ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .PACKET_TIMEOUT(PTO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .host       (intf.slave),
    .key_clk_i  (key_clk_i),
    .key_data_i (key_data_i),
    .key_clk_oe (key_clk_oe),
    .key_data_oe(key_data_oe)
  );

  // Open-collector bus: a line is low if either side pulls it.
  assign key_clk_i  = ~(key_clk_oe | dev_clk_low);
  assign key_data_i = ~(key_data_oe | dev_data_low);

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          glitch;
    bit          poke;
    logic [10:0] bits;
    bit          exp_done;
  } vec_t;

  // Cycle-level observers: pulse counts, inhibit/RTS lengths and the error cycle.
  int cyc = 0, done_cnt = 0, err_cnt = 0, inh_len = 0, rts_len = 0;
  int rts_cyc = 0, err_cyc = 0, last_code = 0, err_oe = 0;
  always @(negedge clk_in) begin
    cyc++;
    if (key_clk_oe && !key_data_oe) inh_len++;
    if (key_clk_oe && key_data_oe) begin
      rts_len++;
      rts_cyc = cyc;
    end
    if (intf.done) done_cnt++;
    if (intf.err) begin
      err_cnt++;
      last_code = int'(intf.err_code);
      err_cyc = cyc;
      err_oe = int'(key_clk_oe | key_data_oe);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame as the keyboard sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    p = ((ones % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    intf.tx_data  = d;
    intf.tx_valid = 1'b1;
    @(negedge clk_in);
    intf.tx_valid = 1'b0;
  endtask

  // Keyboard model: 10-cycle low / 10-cycle high clock, samples on rising edges.
  // stop_after > 0 abandons the frame with the clock held low after that falling edge.
  task automatic device_frame(input bit do_ack, input bit glitch, input int stop_after,
                              output logic [10:0] cap, output bit started);
    int t = 0;
    cap = '0;
    started = 1'b0;
    while (!(key_data_i == 1'b0 && key_clk_oe == 1'b0) && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 2000) return;
    started = 1'b1;
    cap[0] = key_data_i;
    repeat (20) @(negedge clk_in);
    if (glitch) begin
      dev_clk_low = 1'b1;
      repeat (2) @(negedge clk_in);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk_in);
    end
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk_in);
      if (k == stop_after) return;
      dev_clk_low = 1'b0;
      cap[k] = key_data_i;
      repeat (10) @(negedge clk_in);
    end
    repeat (5) @(negedge clk_in);
    if (do_ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk_in);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk_in);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk_in);
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit glitch,
                           input bit poke, input logic [10:0] exp_bits,
                           input bit exp_done, input string tag);
    logic [10:0] cap;
    bit started;
    int b_done, b_err, b_inh, b_rts, t;
    b_done = done_cnt;
    b_err  = err_cnt;
    b_inh  = inh_len;
    b_rts  = rts_len;
    check({tag, " ready before"}, int'(intf.tx_ready), 1);
    send_byte(d);
    if (poke) fork
      begin
        repeat (80) @(negedge clk_in);
        intf.tx_data  = 8'hC3;
        intf.tx_valid = 1'b1;
        @(negedge clk_in);
        intf.tx_valid = 1'b0;
      end
    join_none
    device_frame(do_ack, glitch, 0, cap, started);
    t = 0;
    while (!intf.tx_ready && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    repeat (40) @(negedge clk_in);
    check({tag, " started"}, int'(started), 1);
    check({tag, " bits"}, int'(cap), int'(exp_bits));
    check({tag, " done"}, done_cnt - b_done, int'(exp_done));
    check({tag, " err"}, err_cnt - b_err, int'(!exp_done));
    if (!exp_done) check({tag, " code"}, last_code, 3);
    check({tag, " inhibit len"}, inh_len - b_inh, INH);
    check({tag, " rts len"}, rts_len - b_rts, 1);
    check({tag, " ready after"}, int'(intf.tx_ready), 1);
    check({tag, " busy after"}, int'(intf.busy), 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [10:0] cap;
    bit started;
    int b_done, b_err, t, lat;
    logic [7:0] rd;
    bit rack;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80, 1'b0}, 1'b1};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b1};

    intf.tx_data  = 8'h00;
    intf.tx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset tx_ready", int'(intf.tx_ready), 1);
    check("reset busy", int'(intf.busy), 0);
    check("reset rx_inhibit", int'(intf.rx_inhibit), 0);
    check("reset done", int'(intf.done), 0);
    check("reset err", int'(intf.err), 0);
    check("reset err_code", int'(intf.err_code), 0);
    check("reset oe", int'({key_clk_oe, key_data_oe}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_in);

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].glitch, vecs[i].poke,
                vecs[i].bits, vecs[i].exp_done, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      run_frame(rd, rack, 1'b0, 1'b0, model_frame(rd), rack, $sformatf("rnd%0d", i));
    end

    // No device response after request-to-send.
    b_done = done_cnt;
    b_err  = err_cnt;
    send_byte(8'h42);
    t = 0;
    while (err_cnt == b_err && t < INH + STO + 100) begin
      @(negedge clk_in);
      t++;
    end
    @(negedge clk_in);
    lat = err_cyc - rts_cyc;
    check("start timeout err", err_cnt - b_err, 1);
    check("start timeout code", last_code, 1);
    check("start timeout oe", err_oe, 0);
    check("start timeout latency", int'(lat >= STO && lat <= STO + 2), 1);
    check("start timeout done", done_cnt - b_done, 0);
    repeat (10) @(negedge clk_in);

    // Device stalls after three edges.
    b_done = done_cnt;
    b_err  = err_cnt;
    send_byte(8'h96);
    device_frame(1'b1, 1'b0, 3, cap, started);
    dev_clk_low = 1'b0;
    t = 0;
    while (err_cnt == b_err && t < PTO + 100) begin
      @(negedge clk_in);
      t++;
    end
    @(negedge clk_in);
    check("packet timeout err", err_cnt - b_err, 1);
    check("packet timeout code", last_code, 2);
    check("packet timeout oe", err_oe, 0);
    check("packet timeout done", done_cnt - b_done, 0);
    repeat (10) @(negedge clk_in);

    // Reset mid-frame after the fifth falling edge.
    b_done = done_cnt;
    b_err  = err_cnt;
    send_byte(8'hA7);
    device_frame(1'b1, 1'b0, 5, cap, started);
    rst = 1'b1;
    @(negedge clk_in);
    check("midrst clk_oe", int'(key_clk_oe), 0);
    check("midrst data_oe", int'(key_data_oe), 0);
    check("midrst tx_ready", int'(intf.tx_ready), 1);
    check("midrst busy", int'(intf.busy), 0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk_in);
    check("midrst no done", done_cnt - b_done, 0);
    check("midrst no err", err_cnt - b_err, 0);
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, {1'b1, 1'b1, 8'h55, 1'b0}, 1'b1, "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
